// File: rtl/ringosc_pkg.sv
// Shared types and default constants for the ring-oscillator controller/meter.
package ringosc_pkg;

  // Default build constants; the modules expose them as overridable parameters.
  localparam int DEF_CNT_W      = 16;
  localparam int DEF_SEL_W      = 4;
  localparam int DEF_WARMUP_CYC = 16;

  // Measurement sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WARMUP,
    ST_MEASURE,
    ST_DONE
  } state_t;

  // Larger of two integers, used to size the shared warm-up/window timer.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ringosc_meter_sync_edge_det.sv
// Multi-stage synchronizer for the free-running oscillator output, followed by
// a rising-edge detector on the synchronized level.
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Shift the raw level through the synchronizer and keep last cycle's synced value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every stage sample the old value of
      // its neighbour, which is what turns this into a real shift register.
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // A 0 -> 1 step of the synchronized level, valid for exactly one clk cycle.
  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/ringosc_meter.sv
// Ring-oscillator controller and frequency meter: enables the ring, waits for
// it to settle, counts synchronized rising edges over 2^window_sel clk cycles
// and presents the count with a done pulse.
module ringosc_meter
  import ringosc_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SEL_W       = DEF_SEL_W,
  parameter int WARMUP_CYC  = DEF_WARMUP_CYC,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [SEL_W-1:0] window_sel,
  input  logic             osc_in,
  output logic             osc_enable,
  output logic             busy,
  output logic             done,
  output logic             result_valid,
  output logic [CNT_W-1:0] result,
  output logic             overflow
);

  // One down-counter times both the warm-up and the window; it must hold
  // 2^(2^SEL_W - 1) - 1 as well as WARMUP_CYC - 1.
  localparam int             TMR_W     = max_int(2 ** SEL_W, $clog2(WARMUP_CYC) + 1);
  localparam logic [TMR_W-1:0] WARM_LOAD = TMR_W'(WARMUP_CYC - 1);

  state_t           state_q, state_d;
  logic [SEL_W-1:0] sel_q;
  logic [TMR_W-1:0] tmr_q;
  logic [TMR_W-1:0] win_load;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_next;
  logic             sat_q;
  logic             rise;
  logic             tmr_zero;
  logic             cnt_full;
  logic             window_end;

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (osc_in),
    .rise (rise)
  );

  assign tmr_zero   = (tmr_q == '0);
  assign cnt_full   = &cnt_q;
  assign win_load   = (TMR_W'(1) << sel_q) - TMR_W'(1);
  // Count including an edge seen in the final window cycle, saturating at all-ones.
  assign cnt_next   = (rise && !cnt_full) ? cnt_q + CNT_W'(1) : cnt_q;
  // Abort in the last window cycle wins over latching a result.
  assign window_end = (state_q == ST_MEASURE) && tmr_zero && !abort;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: start only from IDLE, abort only while busy.
  always_comb begin
    // NOTE: assigning a default before the case keeps every path driven, so no
    // latch is inferred when a branch leaves the state alone.
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start) state_d = ST_WARMUP;
      ST_WARMUP:  if (abort) state_d = ST_IDLE;
                  else if (tmr_zero) state_d = ST_MEASURE;
      ST_MEASURE: if (abort) state_d = ST_IDLE;
                  else if (tmr_zero) state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Oscillator enable and busy follow the state directly, so reset drops them at once.
  always_comb begin
    osc_enable = 1'b0;
    busy       = 1'b0;
    if (state_q == ST_WARMUP || state_q == ST_MEASURE) begin
      osc_enable = 1'b1;
      busy       = 1'b1;
    end
  end

  // Window latch, warm-up/window timer and saturating edge counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q <= '0;
      tmr_q <= '0;
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            sel_q <= window_sel;
            tmr_q <= WARM_LOAD;
            cnt_q <= '0;
            sat_q <= 1'b0;
          end
        end
        ST_WARMUP: begin
          if (abort)         cnt_q <= '0;
          else if (tmr_zero) tmr_q <= win_load;
          else               tmr_q <= tmr_q - TMR_W'(1);
        end
        ST_MEASURE: begin
          if (abort) begin
            cnt_q <= '0;
          end else begin
            if (rise && cnt_full) sat_q <= 1'b1;
            cnt_q <= cnt_next;
            if (!tmr_zero) tmr_q <= tmr_q - TMR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Published result, flags and the one-cycle done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done         <= 1'b0;
      result_valid <= 1'b0;
      result       <= '0;
      overflow     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state_q == ST_IDLE && start) begin
        result_valid <= 1'b0;
      end else if (window_end) begin
        result       <= cnt_next;
        overflow     <= sat_q | (rise & cnt_full);
        result_valid <= 1'b1;
        done         <= 1'b1;
      end
    end
  end

endmodule
